// File: rtl/adder64_result_accum_if.sv
// Handshake/result bundle between the adder datapath, the result accumulator
// and whatever consumes the accumulated total.
//   master : drives start/num_terms and the adder result (sum, c_out, in_valid),
//            observes in_ready and the accumulator outputs.
//   slave  : the accumulator side.
// Signals:
//   start      begin a new accumulation (honoured only when the accumulator is idle)
//   num_terms  number of terms to accumulate, latched with an accepted start
//   in_valid   sum/c_out carry a valid adder result
//   in_ready   accumulator takes a term this cycle
//   sum/c_out  adder result; c_out is bit WIDTH of the term
//   acc_out    accumulated total (WIDTH+ACC_EXT bits)
//   acc_valid  one-cycle pulse marking acc_out as final
//   overflow   sticky: total did not fit in WIDTH+ACC_EXT bits
//   busy       accumulation in progress or just completing
interface adder64_result_accum_if #(
    parameter int WIDTH   = 64,
    parameter int ACC_EXT = 8,
    parameter int CNT_W   = 16
);
    logic                       start;
    logic [CNT_W-1:0]           num_terms;
    logic                       in_valid;
    logic                       in_ready;
    logic [WIDTH-1:0]           sum;
    logic                       c_out;
    logic [WIDTH+ACC_EXT-1:0]   acc_out;
    logic                       acc_valid;
    logic                       overflow;
    logic                       busy;

    modport master (
        output start, num_terms, in_valid, sum, c_out,
        input  in_ready, acc_out, acc_valid, overflow, busy
    );

    modport slave (
        input  start, num_terms, in_valid, sum, c_out,
        output in_ready, acc_out, acc_valid, overflow, busy
    );
endinterface

// File: rtl/adder64_result_accum.sv
// Accumulates a programmed number of {c_out,sum} adder results into a
// guard-extended register and reports the total with a one-cycle acc_valid
// pulse plus a sticky overflow flag.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; returns to IDLE and clears all state
//   bus    adder64_result_accum_if.slave (start/num_terms, in_valid/in_ready,
//          sum/c_out, acc_out/acc_valid/overflow/busy)
module adder64_result_accum #(
    parameter int WIDTH   = 64,
    parameter int ACC_EXT = 8,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    adder64_result_accum_if.slave  bus
);
    localparam int ACC_W = WIDTH + ACC_EXT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [ACC_W-1:0]   acc_q;
    logic               ovf_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               start_acc;
    logic               accept;
    logic               last_term;
    logic [ACC_W:0]     acc_sum;

    assign start_acc = (state == IDLE) && bus.start;
    assign accept    = (state == ACCUM) && bus.in_valid;
    assign last_term = (cnt_q == CNT_W'(1));

    // One extra bit on top of the accumulator captures the carry that drives
    // the sticky overflow flag; the stored total wraps modulo 2^ACC_W.
    assign acc_sum = {1'b0, acc_q} + {{ACC_EXT{1'b0}}, bus.c_out, bus.sum};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    // A zero-length run skips straight to reporting a zero total.
                    state_nx = (bus.num_terms != '0) ? ACCUM : DONE;
                end
            end
            ACCUM: begin
                if (accept && last_term) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (start_acc) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= bus.num_terms;
        end else if (accept) begin
            acc_q <= acc_sum[ACC_W-1:0];
            ovf_q <= ovf_q | acc_sum[ACC_W];
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.acc_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.acc_out   = acc_q;
    assign bus.overflow  = ovf_q;
endmodule
